video_timing_rx: RTL and testbench
==================================

// Module: video_timing_rx
// PURPOSE
// - Sink-side checker for the VGA-style stream produced by the test pattern generator (vsync/hsync/dval/RGB888).
// - Tracks frame and line boundaries and tags each pixel with x/y coordinates.
// - Measures active width and height, checks them against expected values, and reports lock and error status.
// - Sits at the capture end of the video path, ahead of frame buffering or pattern checkers.
// PARAMETERS
// - EXP_HACT     640  expected active pixels per line
// - EXP_VACT     480  expected active lines per frame
// - LOCK_FRAMES  2    consecutive good frames required to assert lock_o (>=1)
// - CNT_W        12   width of the x, y and measurement counters
// PORTS
// - px_clk        in   1      pixel clock; all logic on its rising edge
// - sys_rst_n     in   1      asynchronous, active-low reset
// - vsync_i       in   1      high while the frame's active region is in progress
// - hsync_i       in   1      line window; passed through only, not used for counting
// - dval_i        in   1      high on each active pixel
// - rdata_i/gdata_i/bdata_i  in  8 each  pixel colour
// - dval_o        out  1      registered dval, forced to 0 outside frame ACTIVE
// - rdata_o/gdata_o/bdata_o  out 8 each  registered colour (1-cycle latency)
// - x_o, y_o      out  CNT_W  coordinates of the pixel on the *_o bus
// - sof_o         out  1      high with the first pixel of a frame (x=0, y=0)
// - eol_o         out  1      high with the last pixel of a line
// - meas_hact_o   out  CNT_W  pixel count of the most recent line
// - meas_vact_o   out  CNT_W  line count of the most recent completed frame
// - hact_err_o    out  1      last frame had at least one line with length != EXP_HACT
// - vact_err_o    out  1      last frame had line count != EXP_VACT
// - lock_o        out  1      stream locked to the expected format
// - frame_cnt_o   out  16     completed-frame counter; wraps 0xFFFF -> 0
// BEHAVIOUR
// - Reset: all outputs are 0; FSM goes to SYNC.
// - Edge detection: vsync_i and dval_i are registered once. Edges are taken from the current vs registered sample.
// - FSM states:
//   - SYNC: wait for vsync_i low -> IDLE. This avoids starting mid-frame after reset.
//   - IDLE: on vsync_i rising -> ACTIVE. Clear the x, y, line count and per-frame error accumulators.
//   - ACTIVE: count pixels and lines. On vsync_i falling -> CHECK.
//   - CHECK: lasts one cycle, then -> IDLE. In this cycle:
//     - Update meas_vact_o, hact_err_o and vact_err_o.
//     - Increment frame_cnt_o.
//     - Update the lock counter.
// - Pixel pipeline, 1-cycle latency (only while in ACTIVE):
//   - dval_o and RGB outputs are dval_i and RGB delayed by one cycle.
//   - x_o increments on each output pixel and returns to 0 after eol_o.
//   - y_o increments after each eol_o.
// - eol_o: asserted on an output pixel when dval_i is 0 in the cycle that pixel leaves the input.
//   - This includes when vsync_i falls on the same cycle.
// - sof_o: asserted on the first output pixel after entering ACTIVE.
// - Line close (on each eol_o):
//   - meas_hact_o <= x_o + 1.
//   - Set the frame's hact error accumulator if (x_o + 1) != EXP_HACT.
//   - Line count increments.
// - vsync_i falling while dval_i is high: the line closes normally, the pixel is emitted, and CHECK follows.
// - dval_i high in SYNC or IDLE: ignored. dval_o stays 0 and no counters move.
// - Saturation: x and the line count saturate at 2^CNT_W-1 and do not wrap. A saturated count always mismatches.
// - Lock counter:
//   - Good frame (no hact or vact error): counter increments, saturating at LOCK_FRAMES. lock_o=1 when it equals LOCK_FRAMES.
//   - Bad frame: counter clears to 0 and lock_o drops in the CHECK cycle.
// - Error flags reflect only the last checked frame; they are not sticky across frames.
// - Frame with zero lines: meas_vact_o=0, vact_err_o=1, meas_hact_o unchanged.
// - Reset asserted mid-frame: everything clears immediately. After release the FSM returns to SYNC and no partial frame is checked.
// TESTING
// 1. Feed 3 frames of 640x480 (dval blocks with idle gaps) -> sof_o once per frame, 480 eol_o per frame.
//    Expected: meas_hact_o=640, meas_vact_o=480, no errors, lock_o=1 after frame 2, frame_cnt_o=3.
// 2. Frame 4 has line 100 at 639 pixels -> hact_err_o=1 and lock_o=0 at CHECK.
//    Two further good frames -> lock_o=1 again.
// 3. Frame with 479 lines -> vact_err_o=1, meas_vact_o=479, lock_o=0.
// 4. Release reset with vsync_i already high, dval toggling -> no dval_o and no frame count until vsync falls and rises.
//    First full frame is then counted as 1.
// 5. vsync_i falls on the same cycle as the last pixel of line 480 -> that pixel is emitted with eol_o=1 and meas_vact_o=480.
// 6. Pulse sys_rst_n low mid-line (x_o=200) -> all outputs 0 asynchronously, frame_cnt_o=0, and recovery as in case 4.

Source files
------------

// File: rtl/video_timing_rx_if.sv
// Pixel stream entering the receiver and the coordinate-tagged pixel bus leaving it.
interface video_timing_rx_if #(
  parameter int CNT_W = 12
);
  logic             vsync_i;
  logic             hsync_i;
  logic             dval_i;
  logic [7:0]       rdata_i;
  logic [7:0]       gdata_i;
  logic [7:0]       bdata_i;
  logic             dval_o;
  logic             hsync_o;
  logic [7:0]       rdata_o;
  logic [7:0]       gdata_o;
  logic [7:0]       bdata_o;
  logic [CNT_W-1:0] x_o;
  logic [CNT_W-1:0] y_o;
  logic             sof_o;
  logic             eol_o;

  modport master (
    output vsync_i, hsync_i, dval_i, rdata_i, gdata_i, bdata_i,
    input  dval_o, hsync_o, rdata_o, gdata_o, bdata_o, x_o, y_o, sof_o, eol_o
  );

  modport slave (
    input  vsync_i, hsync_i, dval_i, rdata_i, gdata_i, bdata_i,
    output dval_o, hsync_o, rdata_o, gdata_o, bdata_o, x_o, y_o, sof_o, eol_o
  );
endinterface

// File: rtl/video_timing_rx.sv
// Capture-side checker for a vsync/dval/RGB888 stream: tags pixels with x/y,
// measures active width/height and reports lock and format errors.
//
// state  | meaning
// SYNC   | after reset, wait for vsync low so a partial frame is never measured
// IDLE   | between frames, wait for vsync rising
// ACTIVE | frame in progress, pixels tagged and counted
// CHECK  | one cycle after vsync falls, frame results committed
module video_timing_rx #(
  parameter int EXP_HACT    = 640,
  parameter int EXP_VACT    = 480,
  parameter int LOCK_FRAMES = 2,
  parameter int CNT_W       = 12
) (
  input  logic             px_clk,
  input  logic             sys_rst_n,
  video_timing_rx_if.slave vid,
  output logic [CNT_W-1:0] meas_hact_o,
  output logic [CNT_W-1:0] meas_vact_o,
  output logic             hact_err_o,
  output logic             vact_err_o,
  output logic             lock_o,
  output logic [15:0]      frame_cnt_o
);
  localparam int               LCK_W   = $clog2(LOCK_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] EXP_H   = CNT_W'(EXP_HACT);
  localparam logic [CNT_W-1:0] EXP_V   = CNT_W'(EXP_VACT);
  localparam logic [LCK_W-1:0] LOCK_N  = LCK_W'(LOCK_FRAMES);
  localparam logic [LCK_W-1:0] LCK_ONE = LCK_W'(1);

  typedef enum logic [1:0] {SYNC, IDLE, ACTIVE, CHECK} state_t;
  state_t state, state_n;

  logic             vs_q, vs_rise, vs_fall;
  logic             pix_in, eol, line_bad, v_bad, hact_bad, frame_good;
  logic             sof_pend, hact_acc;
  logic [CNT_W-1:0] x_cnt, line_cnt, line_len, v_final;
  logic [LCK_W-1:0] lock_cnt, lock_cnt_n;

  assign vs_rise   = vid.vsync_i & ~vs_q;
  assign vs_fall   = ~vid.vsync_i & vs_q;
  assign vid.eol_o = eol;

  always_ff @(posedge px_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= SYNC;
    else            state <= state_n;
  end

  always_comb begin
    state_n    = state;
    lock_cnt_n = '0;
    case (state)
      SYNC:    if (!vid.vsync_i) state_n = IDLE;
      IDLE:    if (vs_rise)      state_n = ACTIVE;
      ACTIVE:  if (vs_fall)      state_n = CHECK;
      CHECK:   state_n = IDLE;
      default: state_n = SYNC;
    endcase
    pix_in = (state == ACTIVE) && vid.dval_i;
    // The last pixel of a frame may still be on the bus during CHECK.
    eol      = vid.dval_o && (!vid.dval_i || (state != ACTIVE));
    line_len = (vid.x_o == CNT_MAX) ? CNT_MAX : vid.x_o + CNT_ONE;
    line_bad = (line_len == CNT_MAX) || (line_len != EXP_H);
    v_final  = (eol && (line_cnt != CNT_MAX)) ? line_cnt + CNT_ONE : line_cnt;
    v_bad    = (v_final == CNT_MAX) || (v_final != EXP_V);
    hact_bad = hact_acc || (eol && line_bad);
    frame_good = !hact_bad && !v_bad;
    if (frame_good) lock_cnt_n = (lock_cnt == LOCK_N) ? lock_cnt : lock_cnt + LCK_ONE;
  end

  always_ff @(posedge px_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vs_q        <= 1'b0;
      vid.dval_o  <= 1'b0;
      vid.hsync_o <= 1'b0;
      vid.rdata_o <= '0;
      vid.gdata_o <= '0;
      vid.bdata_o <= '0;
      vid.x_o     <= '0;
      vid.y_o     <= '0;
      vid.sof_o   <= 1'b0;
      sof_pend    <= 1'b0;
      x_cnt       <= '0;
      line_cnt    <= '0;
      hact_acc    <= 1'b0;
      meas_hact_o <= '0;
      meas_vact_o <= '0;
      hact_err_o  <= 1'b0;
      vact_err_o  <= 1'b0;
      lock_cnt    <= '0;
      lock_o      <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      vs_q        <= vid.vsync_i;
      vid.hsync_o <= vid.hsync_i;
      vid.dval_o  <= pix_in;
      vid.sof_o   <= pix_in & sof_pend;
      if (pix_in) begin
        vid.rdata_o <= vid.rdata_i;
        vid.gdata_o <= vid.gdata_i;
        vid.bdata_o <= vid.bdata_i;
        vid.x_o     <= x_cnt;
        vid.y_o     <= line_cnt;
        sof_pend    <= 1'b0;
        if (x_cnt != CNT_MAX) x_cnt <= x_cnt + CNT_ONE;
      end
      if (eol) begin
        meas_hact_o <= line_len;
        hact_acc    <= hact_acc | line_bad;
        line_cnt    <= v_final;
        x_cnt       <= '0;
      end
      if ((state == IDLE) && vs_rise) begin
        x_cnt    <= '0;
        line_cnt <= '0;
        hact_acc <= 1'b0;
        sof_pend <= 1'b1;
      end
      if (state == CHECK) begin
        meas_vact_o <= v_final;
        hact_err_o  <= hact_bad;
        vact_err_o  <= v_bad;
        frame_cnt_o <= frame_cnt_o + 16'd1;
        lock_cnt    <= lock_cnt_n;
        lock_o      <= (lock_cnt_n == LOCK_N);
      end
    end
  end
endmodule

// File: tb/tb_video_timing_rx.sv
// Randomized frame stimulus for video_timing_rx, checked against a model built
// from the frame plan (line lengths) rather than from the receiver's internals.
module tb_video_timing_rx;
  localparam int CW   = 6;
  localparam int EH   = 12;
  localparam int EV   = 6;
  localparam int LF   = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic          px_clk = 1'b0;
  logic          sys_rst_n;
  logic [CW-1:0] meas_hact, meas_vact;
  logic          hact_err, vact_err, lock;
  logic [15:0]   frame_cnt;

  video_timing_rx_if #(.CNT_W(CW)) vif ();

  video_timing_rx #(
    .EXP_HACT(EH), .EXP_VACT(EV), .LOCK_FRAMES(LF), .CNT_W(CW)
  ) dut (
    .px_clk      (px_clk),
    .sys_rst_n   (sys_rst_n),
    .vid         (vif),
    .meas_hact_o (meas_hact),
    .meas_vact_o (meas_vact),
    .hact_err_o  (hact_err),
    .vact_err_o  (vact_err),
    .lock_o      (lock),
    .frame_cnt_o (frame_cnt)
  );

  always #5 px_clk = ~px_clk;

  typedef struct packed {
    logic [7:0]    r, g, b;
    logic [CW-1:0] x, y;
    logic          sof, eol;
  } pix_t;

  pix_t exp_q[$];
  int   plan[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_frames, m_lock_cnt, m_meas_h, m_meas_v;
  bit   m_herr, m_verr;
  logic hs_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, req, $time);
  endtask

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic model_reset();
    m_frames = 0; m_lock_cnt = 0; m_meas_h = 0; m_meas_v = 0;
    m_herr = 1'b0; m_verr = 1'b0;
  endtask

  // Every output pixel must match the next planned pixel, in order.
  always @(negedge px_clk) begin
    pix_t a, e;
    if (sys_rst_n) begin
      chk("hsync_o", 64'(vif.hsync_o), 64'(hs_prev));
      if (vif.dval_o) begin
        if (exp_q.size() == 0) chk("unexpected_pixel", 64'(vif.dval_o), 64'd0);
        else begin
          e = exp_q.pop_front();
          a = {vif.rdata_o, vif.gdata_o, vif.bdata_o, vif.x_o, vif.y_o, vif.sof_o, vif.eol_o};
          chk("pixel", 64'(a), 64'(e));
        end
      end else begin
        chk("idle_marks", 64'({vif.sof_o, vif.eol_o}), 64'd0);
      end
      hs_prev = vif.hsync_i;
    end else begin
      hs_prev = 1'b0;
    end
  end

  task automatic px(input bit vs, input bit dv, input bit expect_pix,
                    input int x, input int y, input bit sof, input bit eol);
    pix_t e;
    vif.vsync_i = vs;
    vif.dval_i  = dv;
    vif.hsync_i = dv;
    vif.rdata_i = 8'($urandom);
    vif.gdata_i = 8'($urandom);
    vif.bdata_i = 8'($urandom);
    if (expect_pix) begin
      e.r = vif.rdata_i; e.g = vif.gdata_i; e.b = vif.bdata_i;
      e.x = CW'(x); e.y = CW'(y); e.sof = sof; e.eol = eol;
      exp_q.push_back(e);
    end
    @(posedge px_clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    chk({name, "_pix"}, 64'({vif.dval_o, vif.hsync_o, vif.sof_o, vif.eol_o, vif.rdata_o,
                             vif.gdata_o, vif.bdata_o, vif.x_o, vif.y_o}), 64'd0);
    chk({name, "_stat"}, 64'({meas_hact, meas_vact, hact_err, vact_err, lock, frame_cnt}), 64'd0);
  endtask

  task automatic check_status();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("meas_hact", 64'(meas_hact), 64'(m_meas_h));
    chk("meas_vact", 64'(meas_vact), 64'(m_meas_v));
    chk("hact_err", 64'(hact_err), 64'(m_herr));
    chk("vact_err", 64'(vact_err), 64'(m_verr));
    chk("lock", 64'(lock), 64'(m_lock_cnt == LF));
    chk("frame_cnt", 64'(frame_cnt), 64'(m_frames));
  endtask

  task automatic std_plan(input int nl, input int len);
    plan = {};
    for (int l = 0; l < nl; l++) plan.push_back(len);
  endtask

  task automatic run_frame(input bit fall_last, input bit counted);
    int nl;
    bit last, drop, bad_h, bad_v;
    nl = plan.size();
    px(1, 0, 0, 0, 0, 0, 0);
    repeat ($urandom_range(0, 2)) px(1, 0, 0, 0, 0, 0, 0);
    for (int l = 0; l < nl; l++) begin
      for (int i = 0; i < plan[l]; i++) begin
        last = (i == plan[l] - 1);
        drop = fall_last && last && (l == nl - 1);
        px(!drop, 1, counted, sat(i), sat(l), (l == 0) && (i == 0), last);
      end
      if (!(fall_last && (l == nl - 1))) repeat ($urandom_range(1, 3)) px(1, 0, 0, 0, 0, 0, 0);
    end
    repeat ($urandom_range(3, 5)) px(0, 0, 0, 0, 0, 0, 0);
    if (counted) begin
      bad_h = 1'b0;
      foreach (plan[l]) if ((plan[l] != EH) || (plan[l] >= MAXC)) bad_h = 1'b1;
      bad_v = (nl != EV) || (nl >= MAXC);
      m_frames = (m_frames + 1) & 16'hFFFF;
      if (nl > 0) m_meas_h = sat(plan[nl - 1]);
      m_meas_v = sat(nl);
      m_herr = bad_h;
      m_verr = bad_v;
      m_lock_cnt = (bad_h || bad_v) ? 0 : ((m_lock_cnt < LF) ? m_lock_cnt + 1 : LF);
      check_status();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, actual running required finished");
    $fatal(1);
  end

  initial begin
    int nl;
    sys_rst_n = 1'b0;
    vif.vsync_i = 1'b1; vif.hsync_i = 1'b0; vif.dval_i = 1'b0;
    vif.rdata_i = '0; vif.gdata_i = '0; vif.bdata_i = '0;
    model_reset();
    repeat (3) @(posedge px_clk);
    #1;
    check_zero("reset");
    sys_rst_n = 1'b1;

    // Released with vsync already high: the partial frame must be ignored.
    repeat (20) px(1, 1'($urandom_range(0, 1)), 0, 0, 0, 0, 0);
    chk("no_count_partial", 64'(frame_cnt), 64'd0);
    repeat (3) px(0, 0, 0, 0, 0, 0, 0);

    for (int f = 0; f < 3; f++) begin
      std_plan(EV, EH);
      run_frame(0, 1);
      if (f == 0) chk("lock_after_first", 64'(lock), 64'd0);
    end
    chk("three_frames", 64'({frame_cnt, lock, meas_hact, meas_vact}), 64'({16'd3, 1'b1, 6'd12, 6'd6}));

    std_plan(EV, EH);
    plan[3] = EH - 1;
    run_frame(0, 1);
    chk("short_line", 64'({hact_err, vact_err, lock}), 64'({1'b1, 1'b0, 1'b0}));
    repeat (2) begin std_plan(EV, EH); run_frame(0, 1); end
    chk("relock", 64'(lock), 64'd1);

    std_plan(EV - 1, EH);
    run_frame(0, 1);
    chk("short_frame", 64'({vact_err, meas_vact, lock}), 64'({1'b1, 6'd5, 1'b0}));

    std_plan(EV, EH);
    run_frame(1, 1);
    chk("fall_on_last_px", 64'({vact_err, hact_err, meas_vact}), 64'({1'b0, 1'b0, 6'd6}));

    plan = {};
    run_frame(0, 1);
    chk("zero_lines", 64'({vact_err, meas_vact, meas_hact}), 64'({1'b1, 6'd0, 6'd12}));

    std_plan(EV, EH);
    plan[EV - 1] = 70;
    run_frame(0, 1);
    chk("x_saturate", 64'({meas_hact, hact_err}), 64'({6'd63, 1'b1}));
    std_plan(65, 2);
    run_frame(0, 1);
    chk("y_saturate", 64'({meas_vact, vact_err}), 64'({6'd63, 1'b1}));

    repeat (8) begin
      nl = ($urandom_range(0, 2) != 0) ? EV : int'($urandom_range(EV - 2, EV + 2));
      plan = {};
      for (int l = 0; l < nl; l++)
        plan.push_back(($urandom_range(0, 4) != 0) ? EH : int'($urandom_range(EH - 2, EH + 2)));
      run_frame(1'($urandom_range(0, 1)), 1);
    end

    // Reset pulse in the middle of a line.
    repeat (3) px(0, 0, 0, 0, 0, 0, 0);
    px(1, 0, 0, 0, 0, 0, 0);
    px(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) px(1, 1, 1, i, 0, i == 0, 0);
    chk("x_before_reset", 64'(vif.x_o), 64'd6);
    sys_rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    exp_q.delete();
    model_reset();
    repeat (3) px(1, 1'($urandom_range(0, 1)), 0, 0, 0, 0, 0);
    sys_rst_n = 1'b1;
    repeat (10) px(1, 1'($urandom_range(0, 1)), 0, 0, 0, 0, 0);
    chk("no_count_after_reset", 64'(frame_cnt), 64'd0);
    repeat (3) px(0, 0, 0, 0, 0, 0, 0);
    std_plan(EV, EH);
    run_frame(0, 1);
    chk("count_after_recovery", 64'(frame_cnt), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
